// File: rtl/gcn_transform_fsm.sv
// Sequencer for the feature x weight transformation stage (FM_WM = features x weights).
// It owns the external read port, loads the weights, then walks every (row, column) through a dot product and a write.
module gcn_transform_fsm #(
    parameter int WEIGHT_COLS           = 3,
    parameter int FEATURE_ROWS          = 6,
    parameter int ADDRESS_WIDTH         = 13,
    parameter int FEATURE_BASE          = 512,
    parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
    parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    output logic                             o_enable_read,
    output logic [ADDRESS_WIDTH-1:0]         o_read_address,
    output logic                             o_enable_write_weight,
    output logic                             o_enable_scratch_pad,
    output logic                             o_enable_dot,
    output logic                             o_enable_write_fm_wm,
    output logic [COUNTER_WEIGHT_WIDTH-1:0]  o_weight_count,
    output logic [COUNTER_FEATURE_WIDTH-1:0] o_feature_count,
    output logic                             o_done_trans
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        READ_F,
        COMPUTE,
        WRITE,
        DONE
    } state_t;

    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  LAST_W = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);
    localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_F = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);

    state_t                           r_state;
    state_t                           w_next_state;
    logic [COUNTER_WEIGHT_WIDTH-1:0]  r_weight_count;
    logic [COUNTER_WEIGHT_WIDTH-1:0]  w_next_weight_count;
    logic [COUNTER_FEATURE_WIDTH-1:0] r_feature_count;
    logic [COUNTER_FEATURE_WIDTH-1:0] w_next_feature_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_weight_count  <= '0;
            r_feature_count <= '0;
        end else begin
            r_state         <= w_next_state;
            r_weight_count  <= w_next_weight_count;
            r_feature_count <= w_next_feature_count;
        end
    end

    // Outputs depend only on the registered state and counters, so start never reaches them combinationally.
    always_comb begin
        w_next_state          = r_state;
        w_next_weight_count   = r_weight_count;
        w_next_feature_count  = r_feature_count;
        o_enable_read         = 1'b0;
        o_read_address        = '0;
        o_enable_write_weight = 1'b0;
        o_enable_scratch_pad  = 1'b0;
        o_enable_dot          = 1'b0;
        o_enable_write_fm_wm  = 1'b0;
        o_done_trans          = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state         = LOAD_W;
                    w_next_weight_count  = '0;
                    w_next_feature_count = '0;
                end
            end
            LOAD_W: begin
                o_enable_read         = 1'b1;
                o_enable_write_weight = 1'b1;
                o_read_address        = ADDRESS_WIDTH'(r_weight_count);
                if (r_weight_count == LAST_W) begin
                    w_next_weight_count = '0;
                    w_next_state        = READ_F;
                end else begin
                    w_next_weight_count = r_weight_count + 1'b1;
                end
            end
            READ_F: begin
                o_enable_read        = 1'b1;
                o_enable_scratch_pad = 1'b1;
                o_read_address       = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(r_feature_count);
                w_next_state         = COMPUTE;
            end
            COMPUTE: begin
                o_enable_dot = 1'b1;
                w_next_state = WRITE;
            end
            WRITE: begin
                o_enable_write_fm_wm = 1'b1;
                if (r_weight_count < LAST_W) begin
                    w_next_weight_count = r_weight_count + 1'b1;
                    w_next_state        = COMPUTE;
                end else if (r_feature_count < LAST_F) begin
                    w_next_weight_count  = '0;
                    w_next_feature_count = r_feature_count + 1'b1;
                    w_next_state         = READ_F;
                end else begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                o_done_trans = 1'b1;
                if (!i_start) begin
                    w_next_state         = IDLE;
                    w_next_weight_count  = '0;
                    w_next_feature_count = '0;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign o_weight_count  = r_weight_count;
    assign o_feature_count = r_feature_count;

endmodule

// File: tb/tb_gcn_transform_fsm.sv
// Directed bench for gcn_transform_fsm: each scenario task drives the block and checks
// the packed output vector against a cycle-indexed model of the default-parameter run.
module tb_gcn_transform_fsm;

    logic        clk;
    logic        reset;
    logic        start;
    logic        enable_read;
    logic [12:0] read_address;
    logic        enable_write_weight;
    logic        enable_scratch_pad;
    logic        enable_dot;
    logic        enable_write_fm_wm;
    logic [1:0]  weight_count;
    logic [2:0]  feature_count;
    logic        done_trans;

    int nAsserts = 0;
    int nFails   = 0;

    gcn_transform_fsm dut (
        .i_clk                 (clk),
        .i_reset               (reset),
        .i_start               (start),
        .o_enable_read         (enable_read),
        .o_read_address        (read_address),
        .o_enable_write_weight (enable_write_weight),
        .o_enable_scratch_pad  (enable_scratch_pad),
        .o_enable_dot          (enable_dot),
        .o_enable_write_fm_wm  (enable_write_fm_wm),
        .o_weight_count        (weight_count),
        .o_feature_count       (feature_count),
        .o_done_trans          (done_trans)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed layout: {read, addr[12:0], wr_weight, scratch, dot, wr_fm_wm, wc[1:0], fc[2:0], done}
    function automatic logic [23:0] observed();
        return {enable_read, read_address, enable_write_weight, enable_scratch_pad,
                enable_dot, enable_write_fm_wm, weight_count, feature_count, done_trans};
    endfunction

    // Expected outputs n cycles after the edge that sampled start in IDLE.
    // 3 weight loads, then per row: READ_F followed by 3 x (COMPUTE, WRITE); DONE from n = 45.
    function automatic logic [23:0] model_vec(int n);
        logic        rd;
        logic [12:0] a;
        logic        ew, esp, ed, ef, dn;
        logic [1:0]  wc;
        logic [2:0]  fc;
        int          m, row, p;
        rd = 0; a = '0; ew = 0; esp = 0; ed = 0; ef = 0; dn = 0; wc = '0; fc = '0;
        if (n < 3) begin
            rd = 1; ew = 1; a = 13'(n); wc = 2'(n);
        end else if (n < 45) begin
            m   = n - 3;
            row = m / 7;
            p   = m % 7;
            fc  = 3'(row);
            if (p == 0) begin
                rd = 1; esp = 1; a = 13'(512 + row);
            end else begin
                wc = 2'((p - 1) / 2);
                if (p % 2 == 1) ed = 1;
                else            ef = 1;
            end
        end else begin
            dn = 1; wc = 2'd2; fc = 3'd5;
        end
        return {rd, a, ew, esp, ed, ef, wc, fc, dn};
    endfunction

    task automatic test_reset();
        logic [23:0] got;
        int          enCount;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            got = observed();
            nAsserts++;
            if (got !== 24'h0) begin
                nFails++;
                $display("[TB] FAIL reset_hold got=%h exp=%h", got, 24'h0);
            end
        end
        reset = 1'b0;
        enCount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            got = observed();
            nAsserts++;
            if (got !== 24'h0) begin
                nFails++;
                $display("[TB] FAIL idle_quiet cycle=%0d got=%h exp=%h", i, got, 24'h0);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_full_run();
        logic [23:0] got, exp;
        int          fmPulses, wPulses, spPulses, hot;
        fmPulses = 0; wPulses = 0; spPulses = 0;
        start = 1'b1;
        for (int n = 0; n <= 45; n++) begin
            @(negedge clk);
            got = observed();
            exp = model_vec(n);
            nAsserts++;
            if (got !== exp) begin
                nFails++;
                $display("[TB] FAIL full_run n=%0d got=%h exp=%h", n, got, exp);
            end
            hot = int'(enable_write_weight) + int'(enable_scratch_pad) + int'(enable_dot) + int'(enable_write_fm_wm);
            nAsserts++;
            if (hot !== ((n < 45) ? 1 : 0)) begin
                nFails++;
                $display("[TB] FAIL enable_onehot n=%0d got=%0d exp=%0d", n, hot, (n < 45) ? 1 : 0);
            end
            if (enable_write_weight) wPulses++;
            if (enable_scratch_pad)  spPulses++;
            if (enable_write_fm_wm) begin
                nAsserts++;
                if ({feature_count, weight_count} !== {3'(fmPulses / 3), 2'(fmPulses % 3)}) begin
                    nFails++;
                    $display("[TB] FAIL fm_wm_order pulse=%0d got=%0d,%0d exp=%0d,%0d",
                             fmPulses, feature_count, weight_count, fmPulses / 3, fmPulses % 3);
                end
                fmPulses++;
            end
        end
        nAsserts++;
        if (fmPulses !== 18) begin
            nFails++;
            $display("[TB] FAIL fm_wm_count got=%0d exp=18", fmPulses);
        end
        nAsserts++;
        if (wPulses !== 3) begin
            nFails++;
            $display("[TB] FAIL weight_count_pulses got=%0d exp=3", wPulses);
        end
        nAsserts++;
        if (spPulses !== 6) begin
            nFails++;
            $display("[TB] FAIL scratch_pulses got=%0d exp=6", spPulses);
        end
        start = 1'b0;
        @(negedge clk);
        got = observed();
        nAsserts++;
        if (got !== 24'h0) begin
            nFails++;
            $display("[TB] FAIL full_run_idle got=%h exp=%h", got, 24'h0);
        end
        $display("[TB] test_full_run done");
    endtask

    task automatic test_start_drop();
        logic [23:0] got, exp;
        start = 1'b1;
        for (int n = 0; n <= 46; n++) begin
            @(negedge clk);
            got = observed();
            exp = (n <= 45) ? model_vec(n) : 24'h0;
            nAsserts++;
            if (got !== exp) begin
                nFails++;
                $display("[TB] FAIL start_drop n=%0d got=%h exp=%h", n, got, exp);
            end
            if (n == 19) start = 1'b0;
        end
        $display("[TB] test_start_drop done");
    endtask

    task automatic test_reset_mid();
        logic [23:0] got, exp;
        start = 1'b1;
        for (int n = 0; n <= 26; n++) begin
            @(negedge clk);
            got = observed();
            exp = model_vec(n);
            nAsserts++;
            if (got !== exp) begin
                nFails++;
                $display("[TB] FAIL pre_reset n=%0d got=%h exp=%h", n, got, exp);
            end
        end
        nAsserts++;
        if ({enable_write_fm_wm, feature_count} !== {1'b1, 3'd3}) begin
            nFails++;
            $display("[TB] FAIL in_write_row3 got=%b,%0d exp=1,3", enable_write_fm_wm, feature_count);
        end
        reset = 1'b1;
        @(negedge clk);
        got = observed();
        nAsserts++;
        if (got !== 24'h0) begin
            nFails++;
            $display("[TB] FAIL mid_reset got=%h exp=%h", got, 24'h0);
        end
        reset = 1'b0;
        for (int n = 0; n <= 45; n++) begin
            @(negedge clk);
            got = observed();
            exp = model_vec(n);
            nAsserts++;
            if (got !== exp) begin
                nFails++;
                $display("[TB] FAIL post_reset_run n=%0d got=%h exp=%h", n, got, exp);
            end
        end
        start = 1'b0;
        @(negedge clk);
        got = observed();
        nAsserts++;
        if (got !== 24'h0) begin
            nFails++;
            $display("[TB] FAIL post_reset_idle got=%h exp=%h", got, 24'h0);
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        logic [23:0] got, exp;
        start = 1'b1;
        for (int n = 0; n <= 55; n++) begin
            @(negedge clk);
            got = observed();
            exp = model_vec((n <= 45) ? n : 45);
            nAsserts++;
            if (got !== exp) begin
                nFails++;
                $display("[TB] FAIL hold_done n=%0d got=%h exp=%h", n, got, exp);
            end
        end
        start = 1'b0;
        @(negedge clk);
        got = observed();
        nAsserts++;
        if (got !== 24'h0) begin
            nFails++;
            $display("[TB] FAIL gap_idle got=%h exp=%h", got, 24'h0);
        end
        start = 1'b1;
        for (int n = 0; n <= 45; n++) begin
            @(negedge clk);
            got = observed();
            exp = model_vec(n);
            nAsserts++;
            if (got !== exp) begin
                nFails++;
                $display("[TB] FAIL second_run n=%0d got=%h exp=%h", n, got, exp);
            end
        end
        start = 1'b0;
        @(negedge clk);
        got = observed();
        nAsserts++;
        if (got !== 24'h0) begin
            nFails++;
            $display("[TB] FAIL final_idle got=%h exp=%h", got, 24'h0);
        end
        $display("[TB] test_back_to_back done");
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_full_run();
        test_start_drop();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
